mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. Sits between the EX/MEM register and the MEM/WB register, and drives the MEM/WB register's inputs directly.
- Contains the data memory. Supports word, halfword and byte loads and stores, with sign or zero extension on loads.
- Models a configurable number of memory wait states. During wait states it raises Stall to freeze the upstream pipeline and injects a bubble toward write-back.
- Passes the control and destination fields through to the MEM/WB register.

Parameters:
- DEPTH, 256: data memory size in 32-bit words; must be a power of 2.
- AW, 8: word-index width; must equal log2(DEPTH).
- WAIT_CYCLES, 2: stall cycles per memory access. Range 0..15. 0 means single-cycle access.

Ports:
- CLK  input  1  pipeline clock; all state updates on its rising edge.
- RST_N  input  1  asynchronous active-low reset.
- RegW_in  input  1  RegWrite control from EX/MEM.
- MemtoReg_in  input  1  MemtoReg control from EX/MEM.
- MemRead  input  1  load request.
- MemWrite  input  1  store request.
- Size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- Unsigned_ld  input  1  1 = zero-extend sub-word loads; 0 = sign-extend.
- Alu_result  input  32  effective address, also the pass-through ALU result.
- Write_data  input  32  store data; right-aligned for sub-word stores.
- MUX_destination  input  5  destination register number.
- RegW_out  output  1  to MEM/WB RegW_in.
- MemtoReg_out  output  1  to MEM/WB MemtoReg_in.
- Alu_result_out  output  32  to MEM/WB Alu_result.
- Read_data  output  32  extended load data, to MEM/WB Read_data.
- MUX_destination_out  output  5  to MEM/WB MUX_destination.
- Stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM when high.
- Misalign  output  1  combinational flag: current access is misaligned.
- Fault_sticky  output  1  latched misalignment indicator.

Behaviour:
- **Reset (RST_N low, asynchronous):**
  - state=IDLE, cnt=0, Fault_sticky=0.
  - Memory array is not reset.
  - Combinational outputs follow their inputs, with Stall=0.
- **Misalign condition:**
  - Asserted for halfword accesses with Alu_result[0]=1.
  - Asserted for word accesses with Alu_result[1:0]!=0.
  - Evaluated only when MemRead or MemWrite is high.
- **access** = (MemRead|MemWrite) & ~Misalign.
- **Addressing:**
  - Word index = Alu_result[AW+1:2]; upper address bits are ignored, so out-of-range addresses wrap.
  - Byte lanes are little-endian: lane k holds bits 8k+7:8k, selected by Alu_result[1:0].
- **Pass-through fields:** MemtoReg_out, Alu_result_out and MUX_destination_out are combinational copies of their inputs.
- **RegW_out** = RegW_in & ~Stall & ~Misalign.
- **FSM (states IDLE, BUSY; 4-bit counter cnt):**
  - WAIT_CYCLES=0:
    - Stays in IDLE; Stall is always 0.
    - Reads are combinational.
    - Writes commit at the edge that ends the access cycle.
  - WAIT_CYCLES>0, IDLE with access: Stall=1; next state BUSY, cnt=1.
  - BUSY with cnt<WAIT_CYCLES: Stall=1; cnt increments.
  - BUSY with cnt==WAIT_CYCLES:
    - Stall=0 and Read_data is valid this cycle.
    - A store commits at this cycle's rising edge.
    - Next state IDLE, cnt=0.
  - Every access occupies WAIT_CYCLES+1 cycles, with Stall high for the first WAIT_CYCLES of them.
  - Back-to-back accesses restart from IDLE with no idle gap.
- **Input stability:** upstream holds all inputs stable while Stall=1. A store never commits during stall cycles.
- **Loads:**
  - Byte load: the selected lane, sign- or zero-extended per Unsigned_ld.
  - Halfword load: lanes {1,0} or {3,2} selected by Alu_result[1], then extended.
  - Word load: the full word.
  - Read_data is 0 when MemRead=0 or Misalign=1.
- **Stores:**
  - Byte store writes Write_data[7:0] into the selected lane only.
  - Halfword store writes Write_data[15:0] into the selected half only.
  - Word store writes the full word.
  - Other bytes of the word are untouched.
- **MemRead and MemWrite both high:** treated as a store, and Read_data returns the pre-store word contents.
- **Misaligned access:**
  - No memory write and no stall; completes in one cycle.
  - RegW_out is forced to 0.
  - Fault_sticky is set at the next edge and is cleared only by reset.
- **Reset mid-access:** aborts the access with no write; state returns to IDLE immediately.

Test Plan:
- WAIT_CYCLES=2, sw 0xDEADBEEF to 0x10, then lw 0x10 → Stall high 2 cycles per access. Read_data=0xDEADBEEF in the third cycle of the load, with RegW_out=1 only in that cycle.
- Word 0x80FF7F01 at 0x20: lb 0x21 → 0x0000007F; lb 0x22 → 0xFFFFFFFF; lbu 0x22 → 0x000000FF; lh 0x22 → 0xFFFF80FF; lhu 0x22 → 0x000080FF.
- sb 0xAA to 0x23 over word 0x11223344 → word reads 0xAA223344. sh 0x5566 to 0x20 → word reads 0xAA225566.
- lw 0x31 → Misalign=1, Stall=0, RegW_out=0, Read_data=0, Fault_sticky=1 the next cycle. A following aligned lw works normally.
- WAIT_CYCLES=0: lw then sw on consecutive cycles → Stall never asserts, and the data is correct.
- RST_N pulsed low during the first stall cycle of a sw to 0x40 → memory at 0x40 is unchanged, Stall=0, state is IDLE, Fault_sticky=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: data memory with sub-word loads/stores,
// configurable wait states that stall upstream, and pass-through to MEM/WB.
module mem_access_stage #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned AW          = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RegW_in,
    input  logic        MemtoReg_in,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        Unsigned_ld,
    input  logic [31:0] Alu_result,
    input  logic [31:0] Write_data,
    input  logic [4:0]  MUX_destination,
    output logic        RegW_out,
    output logic        MemtoReg_out,
    output logic [31:0] Alu_result_out,
    output logic [31:0] Read_data,
    output logic [4:0]  MUX_destination_out,
    output logic        Stall,
    output logic        Misalign,
    output logic        Fault_sticky
);

    localparam int unsigned CW       = 4;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES);
    localparam logic        HAS_WAIT = (WAIT_CYCLES != 0);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_fault;
    logic [31:0]    r_mem [DEPTH];

    logic           w_req;
    logic           w_misalign;
    logic           w_access;
    logic           w_done;
    logic           w_stall;
    logic           w_commit;
    logic [AW-1:0]  w_idx;
    logic [1:0]     w_off;
    logic [31:0]    w_word;
    logic [7:0]     w_byte;
    logic [15:0]    w_half;
    logic [31:0]    w_load;
    logic [31:0]    w_merged;

    assign w_idx  = Alu_result[AW+1:2];
    assign w_off  = Alu_result[1:0];
    assign w_word = r_mem[w_idx];

    // Alignment check; only meaningful for real memory requests
    always_comb begin
        w_req      = MemRead | MemWrite;
        w_misalign = 1'b0;
        case (Size)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = Alu_result[0];
            default: w_misalign = |Alu_result[1:0];
        endcase
        w_misalign = w_misalign & w_req;
        w_access   = w_req & ~w_misalign;
    end

    // Stall covers the first WAIT_CYCLES cycles of an access; forced low in reset
    always_comb begin
        w_stall  = 1'b0;
        w_done   = 1'b1;
        if (HAS_WAIT) begin
            w_stall = RST_N & (((r_state == S_IDLE) & w_access) |
                               ((r_state == S_BUSY) & (r_cnt != WAIT_LAST)));
            w_done  = (r_state == S_BUSY) & (r_cnt == WAIT_LAST);
        end
        w_commit = RST_N & w_access & MemWrite & w_done;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (HAS_WAIT && w_access) begin
                        r_state <= S_BUSY;
                        r_cnt   <= CW'(1);
                    end
                end
                S_BUSY: begin
                    if (r_cnt == WAIT_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_fault <= 1'b0;
        end else if (w_misalign) begin
            r_fault <= 1'b1;
        end
    end

    // Load lane selection and extension (little-endian lanes)
    always_comb begin
        w_byte = w_word[{w_off, 3'b000} +: 8];
        w_half = w_word[{w_off[1], 4'b0000} +: 16];
        case (Size)
            2'b00:   w_load = {{24{~Unsigned_ld & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{~Unsigned_ld & w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    // Store merge: only the addressed lanes change
    always_comb begin
        w_merged = w_word;
        case (Size)
            2'b00:   w_merged[{w_off, 3'b000} +: 8]     = Write_data[7:0];
            2'b01:   w_merged[{w_off[1], 4'b0000} +: 16] = Write_data[15:0];
            default: w_merged = Write_data;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_commit) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign Read_data           = (MemRead & ~w_misalign) ? w_load : 32'h0;
    assign Stall               = w_stall;
    assign Misalign            = w_misalign;
    assign Fault_sticky        = r_fault;
    assign RegW_out            = RegW_in & ~w_stall & ~w_misalign;
    assign MemtoReg_out        = MemtoReg_in;
    assign Alu_result_out      = Alu_result;
    assign MUX_destination_out = MUX_destination;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a WAIT_CYCLES=2 instance and a
// single-cycle instance share stimulus and are checked against a byte-level model.
module tb_mem_access_stage;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;
    localparam int unsigned WAITN = 2;

    logic        CLK = 1'b0;
    logic        RST_N, rst0_n;
    logic        RegW_in, MemtoReg_in, MemRead, MemWrite, Unsigned_ld;
    logic [1:0]  Size;
    logic [31:0] Alu_result, Write_data;
    logic [4:0]  MUX_destination;

    logic        RegW_out, MemtoReg_out, Stall, Misalign, Fault_sticky;
    logic [31:0] Alu_result_out, Read_data;
    logic [4:0]  MUX_destination_out;
    logic        RegW_out_0, MemtoReg_out_0, Stall_0, Misalign_0, Fault_sticky_0;
    logic [31:0] Alu_result_out_0, Read_data_0;
    logic [4:0]  MUX_destination_out_0;

    always #5 CLK = ~CLK;

    mem_access_stage #(.DEPTH(DEPTH), .AW(AW), .WAIT_CYCLES(WAITN)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .RegW_in(RegW_in), .MemtoReg_in(MemtoReg_in),
        .MemRead(MemRead), .MemWrite(MemWrite), .Size(Size), .Unsigned_ld(Unsigned_ld),
        .Alu_result(Alu_result), .Write_data(Write_data), .MUX_destination(MUX_destination),
        .RegW_out(RegW_out), .MemtoReg_out(MemtoReg_out), .Alu_result_out(Alu_result_out),
        .Read_data(Read_data), .MUX_destination_out(MUX_destination_out),
        .Stall(Stall), .Misalign(Misalign), .Fault_sticky(Fault_sticky));

    mem_access_stage #(.DEPTH(DEPTH), .AW(AW), .WAIT_CYCLES(0)) u_dut0 (
        .CLK(CLK), .RST_N(rst0_n), .RegW_in(RegW_in), .MemtoReg_in(MemtoReg_in),
        .MemRead(MemRead), .MemWrite(MemWrite), .Size(Size), .Unsigned_ld(Unsigned_ld),
        .Alu_result(Alu_result), .Write_data(Write_data), .MUX_destination(MUX_destination),
        .RegW_out(RegW_out_0), .MemtoReg_out(MemtoReg_out_0), .Alu_result_out(Alu_result_out_0),
        .Read_data(Read_data_0), .MUX_destination_out(MUX_destination_out_0),
        .Stall(Stall_0), .Misalign(Misalign_0), .Fault_sticky(Fault_sticky_0));

    typedef struct packed {
        logic        regw;
        logic        m2r;
        logic        mis;
        logic [31:0] alu;
        logic [4:0]  dest;
        logic [3:0]  stalls;
        logic [31:0] rd_a;
        logic [31:0] rd_b;
        logic        st_a;
        logic        st_b;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_mem [2][DEPTH];
    bit          m_sticky [2];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          running = 0;
    int          stall_cnt = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] f_load(logic [31:0] w, int sz, bit uns, int off);
        logic [31:0] v;
        if (sz == 0) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = (w >> (16 * (off / 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] f_store(logic [31:0] old, logic [31:0] wd, int sz, int off);
        logic [31:0] mask;
        int          sh;
        if (sz == 0)      begin sh = 8 * off;        mask = 32'hFF << sh;   end
        else if (sz == 1) begin sh = 16 * (off / 2); mask = 32'hFFFF << sh; end
        else              begin sh = 0;              mask = 32'hFFFF_FFFF;  end
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic issue(bit rw, bit m2r, bit rd, bit wr, logic [1:0] sz, bit uns,
                         logic [31:0] a, logic [31:0] wd, logic [4:0] dst);
        exp_t e;
        int   idx = int'((a / 4) % DEPTH);
        int   off = int'(a % 4);
        int   s   = int'(sz);
        bit   req = rd | wr;
        bit   mis = req && ((s == 1 && off % 2 != 0) || (s >= 2 && off != 0));
        bit   done = 0;
        e.regw   = rw & ~mis;
        e.m2r    = m2r;
        e.mis    = mis;
        e.alu    = a;
        e.dest   = dst;
        e.stalls = (req && !mis) ? 4'(WAITN) : 4'd0;
        e.rd_a   = (rd && !mis) ? f_load(m_mem[0][idx], s, uns, off) : 32'h0;
        e.rd_b   = (rd && !mis) ? f_load(m_mem[1][idx], s, uns, off) : 32'h0;
        e.st_a   = m_sticky[0];
        e.st_b   = m_sticky[1];
        for (int k = 0; k < 2; k++) begin
            if (wr && !mis) m_mem[k][idx] = f_store(m_mem[k][idx], wd, s, off);
            if (mis) m_sticky[k] = 1'b1;
        end
        q.push_back(e);
        RegW_in = rw; MemtoReg_in = m2r; MemRead = rd; MemWrite = wr; Size = sz;
        Unsigned_ld = uns; Alu_result = a; Write_data = wd; MUX_destination = dst;
        running = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            if (!Stall) done = 1;
        end
        if (!done) chk("completion_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: pops one expectation per completed access on the stalling instance;
    // the single-cycle instance is compared in the first cycle of each access.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST_N) begin
            stall_cnt = 0;
        end else if (running) begin
            chk("w0_stall", 32'(Stall_0), 32'd0);
            if (stall_cnt == 0 && q.size() != 0) begin
                e = q[0];
                chk("w0_read_data", Read_data_0, e.rd_b);
                chk("w0_regw", 32'(RegW_out_0), 32'(e.regw));
                chk("w0_misalign", 32'(Misalign_0), 32'(e.mis));
                chk("w0_sticky", 32'(Fault_sticky_0), 32'(e.st_b));
            end
            if (Stall) begin
                stall_cnt++;
                chk("regw_during_stall", 32'(RegW_out), 32'd0);
            end else if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: completion with empty queue at %0t", $time);
            end else begin
                e = q.pop_front();
                chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
                chk("read_data", Read_data, e.rd_a);
                chk("regw", 32'(RegW_out), 32'(e.regw));
                chk("misalign", 32'(Misalign), 32'(e.mis));
                chk("sticky", 32'(Fault_sticky), 32'(e.st_a));
                chk("alu_pass", Alu_result_out, e.alu);
                chk("dest_pass", 32'(MUX_destination_out), 32'(e.dest));
                chk("m2r_pass", 32'(MemtoReg_out), 32'(e.m2r));
                stall_cnt = 0;
            end
        end
    end

    task automatic rand_txn();
        int          kind = int'($urandom_range(0, 7));
        bit          rd   = (kind <= 2) || (kind == 6);
        bit          wr   = (kind >= 3) && (kind <= 6);
        logic [31:0] a    = ($urandom & 32'hFFFF_FC00) | $urandom_range(0, 79);
        issue(1'($urandom), 1'($urandom), rd, wr, 2'($urandom), 1'($urandom),
              a, $urandom, 5'($urandom));
    endtask

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_N = 1'b0; rst0_n = 1'b0;
        RegW_in = 1'b1; MemtoReg_in = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Size = 2'b10; Unsigned_ld = 1'b0; Alu_result = 32'h10; Write_data = 32'h0;
        MUX_destination = 5'd3;
        m_sticky[0] = 1'b0; m_sticky[1] = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_sticky", 32'(Fault_sticky), 32'd0);
        chk("rst_regw", 32'(RegW_out), 32'd1);
        chk("rst_sticky_w0", 32'(Fault_sticky_0), 32'd0);
        #1; RST_N = 1'b1; rst0_n = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 20; i++) issue(0, 0, 0, 1, 2'b10, 0, 32'(i * 4), $urandom, 5'd0);

        issue(0, 0, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 5'd1);
        issue(1, 1, 1, 0, 2'b10, 0, 32'h10, 32'h0, 5'd2);
        issue(0, 0, 0, 1, 2'b10, 0, 32'h20, 32'h80FF7F01, 5'd0);
        issue(1, 1, 1, 0, 2'b00, 0, 32'h21, 32'h0, 5'd4);
        issue(1, 1, 1, 0, 2'b00, 0, 32'h22, 32'h0, 5'd5);
        issue(1, 1, 1, 0, 2'b00, 1, 32'h22, 32'h0, 5'd6);
        issue(1, 1, 1, 0, 2'b01, 0, 32'h22, 32'h0, 5'd7);
        issue(1, 1, 1, 0, 2'b01, 1, 32'h22, 32'h0, 5'd8);
        issue(0, 0, 0, 1, 2'b10, 0, 32'h20, 32'h11223344, 5'd0);
        issue(0, 0, 0, 1, 2'b00, 0, 32'h23, 32'h000000AA, 5'd0);
        issue(1, 1, 1, 0, 2'b10, 0, 32'h20, 32'h0, 5'd9);
        issue(0, 0, 0, 1, 2'b01, 0, 32'h20, 32'h00005566, 5'd0);
        issue(1, 1, 1, 0, 2'b10, 0, 32'h20, 32'h0, 5'd10);
        issue(1, 1, 1, 0, 2'b10, 0, 32'h31, 32'h0, 5'd11);
        issue(1, 1, 1, 0, 2'b10, 0, 32'h30, 32'h0, 5'd12);
        issue(0, 0, 0, 1, 2'b10, 0, 32'h22, 32'hCAFEF00D, 5'd0);
        issue(1, 0, 1, 0, 2'b01, 0, 32'h21, 32'h0, 5'd13);
        issue(1, 1, 1, 0, 2'b10, 0, 32'h20, 32'h0, 5'd14);
        issue(1, 1, 1, 1, 2'b10, 0, 32'h24, 32'h12345678, 5'd15);
        issue(1, 1, 1, 0, 2'b10, 0, 32'h24, 32'h0, 5'd16);
        issue(1, 0, 0, 0, 2'b10, 0, 32'h55, 32'h0, 5'd17);
        issue(1, 1, 1, 0, 2'b11, 0, 32'hFFFF_FC10, 32'h0, 5'd18);

        for (int i = 0; i < 300; i++) rand_txn();

        // Reset during the first stall cycle of a store must leave memory untouched
        chk("sticky_before_rst", 32'(Fault_sticky), 32'(m_sticky[0]));
        RegW_in = 1'b0; MemRead = 1'b0; MemWrite = 1'b1; Size = 2'b10;
        Alu_result = 32'h40; Write_data = 32'h0BADF00D;
        @(negedge CLK);
        chk("abort_stall_pre", 32'(Stall), 32'd1);
        #1; RST_N = 1'b0;
        #1;
        chk("abort_stall_rst", 32'(Stall), 32'd0);
        chk("abort_sticky_rst", 32'(Fault_sticky), 32'd0);
        MemWrite = 1'b0;
        m_sticky[0] = 1'b0;
        @(negedge CLK); #1; RST_N = 1'b1;
        @(posedge CLK); #1;
        issue(1, 1, 1, 0, 2'b10, 0, 32'h40, 32'h0, 5'd19);

        for (int i = 0; i < 40; i++) rand_txn();

        running = 1'b0;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
